// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for an RV32I-subset datapath.
// Runs one instruction at a time through FETCH, DECODE, EXEC, then MEM and/or
// WB, and drives register addresses, ALU control, operand and immediate
// selects, memory strobes and the PC update strobe.
// Optional feature: define RETIRE_CNT_EN to add the 32-bit retire_cnt output,
// which counts PC updates.
module multicycle_ctrl #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [D_WIDTH-1:0] instr,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  input  logic               eq,
  output logic [A_WIDTH-1:0] rs1,
  output logic [A_WIDTH-1:0] rs2,
  output logic [A_WIDTH-1:0] rd,
  output logic               regWrite,
  output logic [2:0]         ALUctrl,
  output logic               ALUsrc,
  output logic [1:0]         imm_src,
  output logic               result_src,
  output logic               pc_en,
  output logic               pc_src,
  output logic               busy,
  output logic               trap
`ifdef RETIRE_CNT_EN
  ,
  output logic [31:0]        retire_cnt
`endif
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE= 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_U = 2'b11;

  // Reset value of the instruction register: addi x0,x0,0.
  localparam logic [D_WIDTH-1:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [D_WIDTH-1:0] instr_reg;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic       is_r;
  logic       is_addi;
  logic       is_lw;
  logic       is_sw;
  logic       is_br;
  logic       is_beq;
  logic       is_lui;
  logic       legal;
  logic [2:0] dec_aluctrl;
  logic       dec_alusrc;
  logic [1:0] dec_imm_src;
  logic       in_instr;

  assign opcode = instr_reg[6:0];
  assign funct3 = instr_reg[14:12];
  assign funct7 = instr_reg[31:25];

  // Decode the latched instruction into class flags and datapath controls.
  always_comb begin
    is_r        = 1'b0;
    is_addi     = 1'b0;
    is_lw       = 1'b0;
    is_sw       = 1'b0;
    is_br       = 1'b0;
    is_beq      = 1'b0;
    is_lui      = 1'b0;
    dec_aluctrl = ALU_ADD;
    dec_alusrc  = 1'b0;
    dec_imm_src = IMM_I;
    unique case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000) begin
          unique case (funct3)
            3'b000:  begin is_r = 1'b1; dec_aluctrl = ALU_ADD; end
            3'b111:  begin is_r = 1'b1; dec_aluctrl = ALU_AND; end
            3'b110:  begin is_r = 1'b1; dec_aluctrl = ALU_OR;  end
            3'b010:  begin is_r = 1'b1; dec_aluctrl = ALU_SLT; end
            default: is_r = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          is_r        = 1'b1;
          dec_aluctrl = ALU_SUB;
        end
      end
      OP_I: begin
        if (funct3 == 3'b000) begin
          is_addi     = 1'b1;
          dec_alusrc  = 1'b1;
          dec_imm_src = IMM_I;
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          is_lw       = 1'b1;
          dec_alusrc  = 1'b1;
          dec_imm_src = IMM_I;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          is_sw       = 1'b1;
          dec_alusrc  = 1'b1;
          dec_imm_src = IMM_S;
        end
      end
      OP_BR: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          is_br       = 1'b1;
          is_beq      = (funct3 == 3'b000);
          dec_aluctrl = ALU_SUB;
          dec_imm_src = IMM_B;
        end
      end
      OP_LUI: begin
        is_lui      = 1'b1;
        dec_alusrc  = 1'b1;
        dec_imm_src = IMM_U;
      end
      default: legal_dummy_nop();
    endcase
  end

  // Kept as a no-op so the default arm of the decode case is explicit.
  function automatic void legal_dummy_nop();
  endfunction

  assign legal = is_r | is_addi | is_lw | is_sw | is_br | is_lui;

  // Register addresses come straight from the latched word; lui reads x0 so the
  // datapath computes 0 + U-immediate.
  assign rs1 = is_lui ? '0 : instr_reg[15 +: A_WIDTH];
  assign rs2 = instr_reg[20 +: A_WIDTH];
  assign rd  = instr_reg[7 +: A_WIDTH];

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Instruction register: captured on the fetch handshake only.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg <= NOP;
    end else if (state_reg == S_FETCH && imem_ack) begin
      instr_reg <= instr;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_FETCH:  if (imem_ack) state_next = S_DECODE;
      S_DECODE: state_next = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_br)              state_next = S_FETCH;
        else if (is_lw || is_sw) state_next = S_MEM;
        else                    state_next = S_WB;
      end
      S_MEM:    if (dmem_ack) state_next = is_lw ? S_WB : S_FETCH;
      S_WB:     state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_FETCH;
    endcase
  end

  // Decoded datapath controls are presented from DECODE until the instruction
  // retires; they read as zero while fetching or trapped.
  assign in_instr = (state_reg == S_DECODE) || (state_reg == S_EXEC) ||
                    (state_reg == S_MEM)    || (state_reg == S_WB);

  // Output logic; strobes are masked by rst so an aborted instruction never
  // writes the regfile or moves the PC.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    regWrite   = 1'b0;
    result_src = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 1'b0;
    trap       = 1'b0;
    busy       = (state_reg != S_FETCH);
    ALUctrl    = in_instr ? dec_aluctrl : ALU_ADD;
    ALUsrc     = in_instr ? dec_alusrc  : 1'b0;
    imm_src    = in_instr ? dec_imm_src : IMM_I;
    unique case (state_reg)
      S_FETCH: imem_req = 1'b1;
      S_EXEC: begin
        if (is_br) begin
          pc_en  = ~rst;
          pc_src = is_beq ? eq : ~eq;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (is_sw && dmem_ack) begin
          pc_en  = ~rst;
          pc_src = 1'b0;
        end
      end
      S_WB: begin
        regWrite   = (rd != '0) & ~rst;
        result_src = is_lw;
        pc_en      = ~rst;
        pc_src     = 1'b0;
      end
      S_TRAP:  trap = 1'b1;
      default: trap = 1'b0;
    endcase
  end

`ifdef RETIRE_CNT_EN
  logic [31:0] retire_cnt_reg;

  // Count retired instructions; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_reg <= 32'd0;
    end else if (pc_en && state_reg != S_TRAP) begin
      retire_cnt_reg <= retire_cnt_reg + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_reg;
`endif

endmodule
